exec_cc_stage: RTL

Execute-stage pipeline register for the 64-bit Y-86 datapath, directly downstream of the ALU. Captures the ALU result and overflow flag with the instruction's control fields, maintains the condition-code register (ZF, SF, OF), evaluates the branch/cmov condition, and hands the bundle to the memory stage over a valid/ready handshake.

---
 rtl/exec_cc_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: execute-stage register with CC (ZF/SF/OF), branch/cmov condition and valid/ready handoff.
//   clk, rst_n (sync, active-low); upstream in_valid/in_ready, in_icode/in_ifun/in_stat,
//   alu_result/alu_overflow, in_valA, in_dstE/in_dstM; cc_hold, flush; downstream out_valid/out_ready,
//   out_icode/out_stat/out_valE/out_valA/out_dstE/out_dstM/out_cnd; cc_zf/cc_sf/cc_of; retire_cnt.
//   Define STAT_HALT_EN to stop the stage after a non-AOK bundle is handed downstream.
module exec_cc_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [2:0]  in_stat,
  input  logic [63:0] alu_result,
  input  logic        alu_overflow,
  input  logic [63:0] in_valA,
  input  logic [3:0]  in_dstE,
  input  logic [3:0]  in_dstM,
  input  logic        cc_hold,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_icode,
  output logic [2:0]  out_stat,
  output logic [63:0] out_valE,
  output logic [63:0] out_valA,
  output logic [3:0]  out_dstE,
  output logic [3:0]  out_dstM,
  output logic        out_cnd,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic [31:0] retire_cnt
);
  typedef enum logic [1:0] {IDLE, FULL, HALT, HALTED} state_t;
  state_t state, acc_state;
  logic cnd, flush_eff, accept, cc_upd;
  assign in_ready  = state == IDLE | (state == FULL & out_ready);
  assign flush_eff = flush & state != HALTED;
  assign accept    = in_valid & in_ready & !flush;
  assign cc_upd    = accept & in_icode == 4'd6 & in_stat == 3'd1 & !cc_hold;
`ifdef STAT_HALT_EN
  assign acc_state = in_stat != 3'd1 ? HALT : FULL;
`else
  assign acc_state = FULL;
`endif
  // condition is taken from the CC value before this bundle's own update
  always_comb begin
    cnd = 1'b0;
    case (in_ifun)
      4'd0: cnd = 1'b1;
      4'd1: cnd = (cc_sf ^ cc_of) | cc_zf;
      4'd2: cnd = cc_sf ^ cc_of;
      4'd3: cnd = cc_zf;
      4'd4: cnd = !cc_zf;
      4'd5: cnd = !(cc_sf ^ cc_of);
      4'd6: cnd = !(cc_sf ^ cc_of) & !cc_zf;
      default: cnd = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_icode  <= '0;
      out_stat   <= '0;
      out_valE   <= '0;
      out_valA   <= '0;
      out_dstE   <= 4'hF;
      out_dstM   <= 4'hF;
      out_cnd    <= 1'b0;
      cc_zf      <= 1'b1;
      cc_sf      <= 1'b0;
      cc_of      <= 1'b0;
      retire_cnt <= '0;
    end else if (flush_eff) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid & out_ready)
        retire_cnt <= retire_cnt + 32'd1;
      if (accept) begin
        state     <= acc_state;
        out_valid <= 1'b1;
        out_icode <= in_icode;
        out_stat  <= in_stat;
        out_valE  <= alu_result;
        out_valA  <= in_valA;
        out_dstM  <= in_dstM;
        out_dstE  <= (in_icode == 4'd2 & !cnd) ? 4'hF : in_dstE;
        out_cnd   <= (in_icode == 4'd2 | in_icode == 4'd7) & cnd;
      end else if (out_valid & out_ready) begin
        state     <= state == HALT ? HALTED : IDLE;
        out_valid <= 1'b0;
      end
      if (cc_upd) begin
        cc_zf <= alu_result == 64'd0;
        cc_sf <= alu_result[63];
        cc_of <= alu_overflow;
      end
    end
  end
endmodule
